// File: rtl/cache_way_ctrl.sv
// Lookup/replacement sequencer for a 4-way set-associative cache.
// A request is latched in IDLE, the tag array is read in LOOKUP, and the four
// way tags are compared in COMPARE. A hit selects the lowest matching way.
// A miss picks a victim, preferring the lowest invalid way and otherwise the
// tree pseudo-LRU way, then holds a refill request until the fill engine
// reports completion. Every outward-facing control bit comes from a flop.
module cache_way_ctrl #(
    parameter int WAYS     = 4,
    parameter int SETS     = 64,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [IDX_BITS-1:0]      i_req_index,
    input  logic [TAG_BITS-1:0]      i_req_tag,
    output logic                     o_tag_rd_en,
    output logic [IDX_BITS-1:0]      o_tag_rd_index,
    input  logic [WAYS*TAG_BITS-1:0] i_tag_rd,
    input  logic [WAYS-1:0]          i_valid_rd,
    output logic                     o_fill_req,
    output logic [WAYS-1:0]          o_fill_way,
    output logic [IDX_BITS-1:0]      o_fill_index,
    output logic [TAG_BITS-1:0]      o_fill_tag,
    input  logic                     i_fill_done,
    output logic [WAYS-1:0]          o_way_sel,
    output logic                     o_hit,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMPARE,
        S_FILL,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic [WAYS-1:0]     victim_q, victim_d;
    logic [WAYS-1:0]     way_sel_q, way_sel_d;
    logic                hit_q, hit_d;
    logic                req_ready_q, req_ready_d;
    logic                tag_rd_en_q, tag_rd_en_d;
    logic                fill_req_q, fill_req_d;
    logic                resp_valid_q, resp_valid_d;

    // One 3-bit tree per set: {b2, b1, b0}.
    logic [2:0]          plru_q [SETS];
    logic                plru_we;
    logic [2:0]          plru_wr_val;
    logic [2:0]          plru_cur;

    logic [WAYS-1:0]     match;
    logic [WAYS-1:0]     hit_oh;
    logic [WAYS-1:0]     inv_oh;
    logic [WAYS-1:0]     plru_oh;

    // Return the tree state after touching the given one-hot way; bits on the
    // other half of the tree are left alone.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAYS-1:0] way_oh);
        logic [2:0] n;
        n = p;
        if (way_oh[0]) begin
            n[0] = 1'b1;
            n[1] = 1'b1;
        end else if (way_oh[1]) begin
            n[0] = 1'b1;
            n[1] = 1'b0;
        end else if (way_oh[2]) begin
            n[0] = 1'b0;
            n[2] = 1'b1;
        end else if (way_oh[3]) begin
            n[0] = 1'b0;
            n[2] = 1'b0;
        end
        return n;
    endfunction

    // Tag comparison and the three one-hot candidates: lowest hit, lowest invalid, tree victim.
    always_comb begin
        logic found_hit;
        logic found_inv;
        match     = '0;
        hit_oh    = '0;
        inv_oh    = '0;
        plru_oh   = '0;
        found_hit = 1'b0;
        found_inv = 1'b0;
        plru_cur  = plru_q[idx_q];
        for (int w = 0; w < WAYS; w++) begin
            match[w] = i_valid_rd[w] && (i_tag_rd[w*TAG_BITS +: TAG_BITS] == tag_q);
            if (match[w] && !found_hit) begin
                hit_oh[w] = 1'b1;
                found_hit = 1'b1;
            end
            if (!i_valid_rd[w] && !found_inv) begin
                inv_oh[w] = 1'b1;
                found_inv = 1'b1;
            end
        end
        if (!plru_cur[0]) begin
            plru_oh = plru_cur[1] ? 4'b0010 : 4'b0001;
        end else begin
            plru_oh = plru_cur[2] ? 4'b1000 : 4'b0100;
        end
    end

    // Sequencer next-state: request latch, hit/miss decision, fill wait and response hold.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        victim_d    = victim_q;
        way_sel_d   = way_sel_q;
        hit_d       = hit_q;
        plru_we     = 1'b0;
        plru_wr_val = plru_cur;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    idx_d   = i_req_index;
                    tag_d   = i_req_tag;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (|match) begin
                    way_sel_d   = hit_oh;
                    hit_d       = 1'b1;
                    plru_we     = 1'b1;
                    plru_wr_val = plru_touch(plru_cur, hit_oh);
                    state_d     = S_RESP;
                end else begin
                    victim_d = (|inv_oh) ? inv_oh : plru_oh;
                    state_d  = S_FILL;
                end
            end
            S_FILL: begin
                if (i_fill_done) begin
                    way_sel_d   = victim_q;
                    hit_d       = 1'b0;
                    plru_we     = 1'b1;
                    plru_wr_val = plru_touch(plru_cur, victim_q);
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d  = (state_d == S_IDLE);
        tag_rd_en_d  = (state_d == S_LOOKUP);
        fill_req_d   = (state_d == S_FILL);
        resp_valid_d = (state_d == S_RESP);
    end

    // State, registered outputs and the per-set PLRU table; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            way_sel_q    <= '0;
            hit_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            tag_rd_en_q  <= 1'b0;
            fill_req_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= 3'b000;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            way_sel_q    <= way_sel_d;
            hit_q        <= hit_d;
            req_ready_q  <= req_ready_d;
            tag_rd_en_q  <= tag_rd_en_d;
            fill_req_q   <= fill_req_d;
            resp_valid_q <= resp_valid_d;
            if (plru_we) begin
                plru_q[idx_q] <= plru_wr_val;
            end
        end
    end

    assign o_req_ready    = req_ready_q;
    assign o_tag_rd_en    = tag_rd_en_q;
    assign o_tag_rd_index = idx_q;
    assign o_fill_req     = fill_req_q;
    assign o_fill_way     = victim_q;
    assign o_fill_index   = idx_q;
    assign o_fill_tag     = tag_q;
    assign o_way_sel      = way_sel_q;
    assign o_hit          = hit_q;
    assign o_resp_valid   = resp_valid_q;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl. The bench holds its own tag/valid array
// and a per-set tree-PLRU model. Each request computes the expected hit way
// or victim from those rules, and the cycle-level sequence is checked against
// that expectation. A negedge compare process checks every cycle that a held
// response or fill request matches the model.
module tb_cache_way_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [5:0]  i_req_index;
    logic [19:0] i_req_tag;
    logic        o_tag_rd_en;
    logic [5:0]  o_tag_rd_index;
    logic [79:0] i_tag_rd;
    logic [3:0]  i_valid_rd;
    logic        o_fill_req;
    logic [3:0]  o_fill_way;
    logic [5:0]  o_fill_index;
    logic [19:0] o_fill_tag;
    logic        i_fill_done;
    logic [3:0]  o_way_sel;
    logic        o_hit;
    logic        o_resp_valid;
    logic        i_resp_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Bench-side tag/valid array and PLRU state, plus the current expectation.
    logic [19:0] tb_tag   [64][4];
    logic [3:0]  tb_valid [64];
    logic [2:0]  tb_plru  [64];
    logic [3:0]  exp_way;
    logic        exp_hit;
    logic [5:0]  exp_idx;
    logic [19:0] exp_tag;
    logic        check_en;
    logic [5:0]  rd_idx;

    cache_way_ctrl #(
        .WAYS(4), .SETS(64), .IDX_BITS(6), .TAG_BITS(20)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_index    (i_req_index),
        .i_req_tag      (i_req_tag),
        .o_tag_rd_en    (o_tag_rd_en),
        .o_tag_rd_index (o_tag_rd_index),
        .i_tag_rd       (i_tag_rd),
        .i_valid_rd     (i_valid_rd),
        .o_fill_req     (o_fill_req),
        .o_fill_way     (o_fill_way),
        .o_fill_index   (o_fill_index),
        .o_fill_tag     (o_fill_tag),
        .i_fill_done    (i_fill_done),
        .o_way_sel      (o_way_sel),
        .o_hit          (o_hit),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready)
    );

    // 10-time-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Model: first way in ascending order that is valid with a matching tag, or -1.
    function automatic int model_hit(input int idx, input logic [19:0] tag);
        for (int w = 0; w < 4; w++) begin
            if (tb_valid[idx][w] && tb_tag[idx][w] == tag) return w;
        end
        return -1;
    endfunction

    // Model: first empty way; with a full set, walk the tree toward the colder half.
    function automatic int model_victim(input int idx);
        logic [2:0] p;
        for (int w = 0; w < 4; w++) begin
            if (!tb_valid[idx][w]) return w;
        end
        p = tb_plru[idx];
        if (p[0] == 1'b0) return (p[1] == 1'b1) ? 1 : 0;
        return (p[2] == 1'b1) ? 3 : 2;
    endfunction

    // Model: after an access, aim the root at the opposite half and the leaf node at the sibling.
    function automatic void model_touch(input int idx, input int way);
        if (way < 2) begin
            tb_plru[idx][0] = 1'b1;
            tb_plru[idx][1] = (way == 0);
        end else begin
            tb_plru[idx][0] = 1'b0;
            tb_plru[idx][2] = (way == 2);
        end
    endfunction

    // Synchronous tag array: a read strobe seen this cycle returns data in the next cycle, then garbage.
    initial begin
        i_tag_rd   = '0;
        i_valid_rd = '0;
        forever begin
            @(negedge i_clk);
            if (o_tag_rd_en === 1'b1) begin
                rd_idx = o_tag_rd_index;
                @(posedge i_clk);
                #1;
                for (int w = 0; w < 4; w++) i_tag_rd[w*20 +: 20] = tb_tag[rd_idx][w];
                i_valid_rd = tb_valid[rd_idx];
                @(posedge i_clk);
                #1;
                for (int w = 0; w < 4; w++) i_tag_rd[w*20 +: 20] = 20'($urandom);
                i_valid_rd = 4'($urandom);
            end
        end
    end

    // Every cycle: a held response or fill request must match the model's expectation.
    always @(negedge i_clk) begin
        if (check_en && i_rst === 1'b0) begin
            checkOutput("way_sel_onehot_or_zero", 32'($countones(o_way_sel) <= 1), 32'd1);
            if (o_resp_valid === 1'b1) begin
                checkOutput("cyc_resp_way_sel", 32'(o_way_sel), 32'(exp_way));
                checkOutput("cyc_resp_hit", 32'(o_hit), 32'(exp_hit));
                checkOutput("cyc_resp_not_ready", 32'(o_req_ready), 32'd0);
            end
            if (o_fill_req === 1'b1) begin
                checkOutput("cyc_fill_way", 32'(o_fill_way), 32'(exp_way));
                checkOutput("cyc_fill_index", 32'(o_fill_index), 32'(exp_idx));
                checkOutput("cyc_fill_tag", 32'(o_fill_tag), 32'(exp_tag));
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] idx, input logic [19:0] tag);
        checkOutput("req_ready_before_accept", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_index = idx;
        i_req_tag   = tag;
        tick();
        i_req_valid = 1'b0;
        i_req_index = 6'($urandom);
        i_req_tag   = 20'($urandom);
    endtask

    // One complete request. lit_way >= 0 pins the outcome with a hand-computed way.
    task automatic do_request(input logic [5:0] idx, input logic [19:0] tag, input int lit_way,
                              input int resp_delay, input int fill_delay, input bit abort_in_fill);
        int hw;
        int way;
        hw      = model_hit(idx, tag);
        way     = (hw >= 0) ? hw : model_victim(idx);
        exp_way = 4'(1 << way);
        exp_hit = (hw >= 0);
        exp_idx = idx;
        exp_tag = tag;

        applyStimulus(idx, tag);
        // T+1: single tag read of the latched set.
        checkOutput("t1_tag_rd_en", 32'(o_tag_rd_en), 32'd1);
        checkOutput("t1_tag_rd_index", 32'(o_tag_rd_index), 32'(idx));
        checkOutput("t1_req_ready", 32'(o_req_ready), 32'd0);
        tick();
        checkOutput("t2_tag_rd_en", 32'(o_tag_rd_en), 32'd0);
        checkOutput("t2_resp_valid", 32'(o_resp_valid), 32'd0);
        checkOutput("t2_fill_req", 32'(o_fill_req), 32'd0);
        tick();
        checkOutput("t3_tag_rd_en", 32'(o_tag_rd_en), 32'd0);

        if (hw >= 0) begin
            checkOutput("t3_hit_resp_valid", 32'(o_resp_valid), 32'd1);
            checkOutput("t3_hit", 32'(o_hit), 32'd1);
            checkOutput("t3_hit_way_sel", 32'(o_way_sel), 32'(exp_way));
            if (lit_way >= 0) checkOutput("lit_hit_way_sel", 32'(o_way_sel), 32'(1 << lit_way));
            model_touch(idx, way);
        end else begin
            checkOutput("t3_fill_req", 32'(o_fill_req), 32'd1);
            checkOutput("t3_fill_way", 32'(o_fill_way), 32'(exp_way));
            checkOutput("t3_miss_resp_valid", 32'(o_resp_valid), 32'd0);
            if (lit_way >= 0) checkOutput("lit_fill_way", 32'(o_fill_way), 32'(1 << lit_way));
            if (abort_in_fill) begin
                #2 i_rst = 1'b1;
                #1;
                checkOutput("abort_fill_req_async", 32'(o_fill_req), 32'd0);
                checkOutput("abort_resp_valid", 32'(o_resp_valid), 32'd0);
                checkOutput("abort_req_ready", 32'(o_req_ready), 32'd1);
                for (int s = 0; s < 64; s++) tb_plru[s] = 3'b000;
                tick();
                tick();
                i_rst       = 1'b0;
                i_fill_done = 1'b1;
                tick();
                i_fill_done = 1'b0;
                checkOutput("stray_fill_done_resp", 32'(o_resp_valid), 32'd0);
                checkOutput("stray_fill_done_ready", 32'(o_req_ready), 32'd1);
                checkOutput("stray_fill_done_fill_req", 32'(o_fill_req), 32'd0);
                return;
            end
            for (int i = 0; i < fill_delay; i++) begin
                tick();
                checkOutput("fill_wait_req", 32'(o_fill_req), 32'd1);
                checkOutput("fill_wait_resp", 32'(o_resp_valid), 32'd0);
            end
            i_fill_done = 1'b1;
            tick();
            i_fill_done = 1'b0;
            checkOutput("fill_resp_valid", 32'(o_resp_valid), 32'd1);
            checkOutput("fill_hit", 32'(o_hit), 32'd0);
            checkOutput("fill_way_sel", 32'(o_way_sel), 32'(exp_way));
            checkOutput("fill_req_dropped", 32'(o_fill_req), 32'd0);
            tb_tag[idx][way]   = tag;
            tb_valid[idx][way] = 1'b1;
            model_touch(idx, way);
        end

        // Response held under backpressure while a competing request is offered.
        for (int i = 0; i < resp_delay; i++) begin
            i_req_valid = 1'b1;
            i_req_index = 6'($urandom);
            i_req_tag   = 20'($urandom);
            tick();
            checkOutput("bp_resp_valid", 32'(o_resp_valid), 32'd1);
            checkOutput("bp_req_ready", 32'(o_req_ready), 32'd0);
            checkOutput("bp_way_sel", 32'(o_way_sel), 32'(exp_way));
        end
        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        checkOutput("release_resp_valid", 32'(o_resp_valid), 32'd0);
        checkOutput("release_req_ready", 32'(o_req_ready), 32'd1);
        checkOutput("release_way_sel_held", 32'(o_way_sel), 32'(exp_way));
    endtask

    initial begin
        check_en     = 1'b0;
        i_rst        = 1'b0;
        i_req_valid  = 1'b0;
        i_req_index  = '0;
        i_req_tag    = '0;
        i_fill_done  = 1'b0;
        i_resp_ready = 1'b0;
        exp_way      = '0;
        exp_hit      = 1'b0;
        exp_idx      = '0;
        exp_tag      = '0;
        for (int s = 0; s < 64; s++) begin
            tb_valid[s] = 4'b0000;
            tb_plru[s]  = 3'b000;
            for (int w = 0; w < 4; w++) tb_tag[s][w] = '0;
        end

        // Reset for two cycles.
        #2 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_req_ready", 32'(o_req_ready), 32'd1);
        checkOutput("rst_fill_req", 32'(o_fill_req), 32'd0);
        checkOutput("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        checkOutput("rst_way_sel", 32'(o_way_sel), 32'd0);
        checkOutput("rst_tag_rd_en", 32'(o_tag_rd_en), 32'd0);
        checkOutput("rst_hit", 32'(o_hit), 32'd0);
        i_rst = 1'b0;
        tick();
        check_en = 1'b1;

        // Cold miss into an empty set: way0.
        do_request(6'd5, 20'hABCDE, 0, 0, 2, 1'b0);

        // Hit in way2 of the same set.
        tb_tag[5][2]   = 20'h12345;
        tb_valid[5][2] = 1'b1;
        do_request(6'd5, 20'h12345, 2, 0, 0, 1'b0);

        // Duplicate tag in ways 1 and 3: the lower way wins.
        tb_tag[7][1] = 20'h11111;
        tb_tag[7][3] = 20'h11111;
        tb_valid[7]  = 4'b1010;
        do_request(6'd7, 20'h11111, 1, 0, 0, 1'b0);

        // Partially valid set: the lowest invalid way is the victim.
        tb_tag[9][0] = 20'h00009;
        tb_tag[9][2] = 20'h00019;
        tb_valid[9]  = 4'b0101;
        do_request(6'd9, 20'h00F09, 1, 0, 1, 1'b0);

        // Full set 0 from reset: tree victims 0,2,1,3,0.
        for (int w = 0; w < 4; w++) tb_tag[0][w] = 20'h00100 + 20'(w);
        tb_valid[0] = 4'b1111;
        do_request(6'd0, 20'h00200, 0, 0, 0, 1'b0);
        do_request(6'd0, 20'h00201, 2, 0, 3, 1'b0);
        do_request(6'd0, 20'h00202, 1, 0, 0, 1'b0);
        do_request(6'd0, 20'h00203, 3, 0, 1, 1'b0);
        do_request(6'd0, 20'h00204, 0, 0, 0, 1'b0);

        // Hit on the freshly filled way0.
        do_request(6'd0, 20'h00204, 0, 0, 0, 1'b0);

        // Ten cycles of response backpressure, then a new request straight after release.
        do_request(6'd5, 20'h12345, 2, 10, 0, 1'b0);
        do_request(6'd5, 20'hABCDE, 0, 0, 0, 1'b0);

        // Reset during a fill to set 0 (tree points at way2), then a miss restarts at way0.
        do_request(6'd0, 20'h00300, 2, 0, 0, 1'b1);
        check_en = 1'b1;
        do_request(6'd0, 20'h00301, 0, 0, 1, 1'b0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
